// File: rtl/sudoku_grid_pixel_gen.sv
// Two-stage pixel generator for the Sudoku board: cell store, grid/box lines, 5x7 digit glyphs, blinking cursor.
// Optional same-digit background highlight enabled by defining SUDOKU_SAME_DIGIT_HL_EN.
module sudoku_grid_pixel_gen #(
  parameter int GRID_N      = 9,
  parameter int BOX_N       = 3,
  parameter int CELL_SIZE   = 52,
  parameter int GLYPH_SCALE = 4,
  parameter int BLINK_DIV   = 25000000,
  parameter int IDX_W       = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       h_cnt,
  input  logic [9:0]       v_cnt,
  input  logic             pix_req,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [3:0]       wr_value,
  input  logic             wr_given,
  input  logic             clr_start,
  input  logic [IDX_W-1:0] cursor_index,
  output logic             busy,
  output logic [11:0]      pixel,
  output logic             pixel_valid
);

  localparam int CELLS = GRID_N * GRID_N;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [9:0] CELL_L  = 10'(CELL_SIZE);
  localparam logic [9:0] GRID_L  = 10'(GRID_N);
  localparam logic [9:0] BOX_L   = 10'(BOX_N);
  localparam logic [9:0] GPX_L   = 10'(GRID_N * CELL_SIZE);
  localparam logic [9:0] SCALE_L = 10'(GLYPH_SCALE);
  localparam logic [9:0] X0_L    = 10'((CELL_SIZE - 5 * GLYPH_SCALE) / 2);
  localparam logic [9:0] Y0_L    = 10'((CELL_SIZE - 7 * GLYPH_SCALE) / 2);
  localparam logic [9:0] GW_L    = 10'(5 * GLYPH_SCALE);
  localparam logic [9:0] GH_L    = 10'(7 * GLYPH_SCALE);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic               busy_q;
  logic [3:0]         value_q [CELLS];
  logic               given_q [CELLS];
  logic [BLINK_W-1:0] blinkCnt_q;
  logic               blinkPhase_q;

  logic [9:0] col_q, row_q, ox_q, oy_q;
  logic       inGrid_q, pixReq_q;
  logic [11:0] pixel_q, pixel_d;
  logic        pixelValid_q;

  // Row r of the 5x7 font for digit d; MSB is the leftmost column, row 0 on top.
  function automatic logic [4:0] fontRow(input logic [3:0] d, input logic [2:0] r);
    logic [34:0] bits;
    case (d)
      4'd1: bits = {5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110};
      4'd2: bits = {5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b11111};
      4'd3: bits = {5'b11111, 5'b00010, 5'b00100, 5'b00010, 5'b00001, 5'b10001, 5'b01110};
      4'd4: bits = {5'b00010, 5'b00110, 5'b01010, 5'b10010, 5'b11111, 5'b00010, 5'b00010};
      4'd5: bits = {5'b11111, 5'b10000, 5'b11110, 5'b00001, 5'b00001, 5'b10001, 5'b01110};
      4'd6: bits = {5'b00110, 5'b01000, 5'b10000, 5'b11110, 5'b10001, 5'b10001, 5'b01110};
      4'd7: bits = {5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01000, 5'b01000};
      4'd8: bits = {5'b01110, 5'b10001, 5'b10001, 5'b01110, 5'b10001, 5'b10001, 5'b01110};
      4'd9: bits = {5'b01110, 5'b10001, 5'b10001, 5'b01111, 5'b00001, 5'b00010, 5'b01100};
      default: bits = '0;
    endcase
    return 5'(bits >> (6'd5 * (6'd6 - 6'(r))));
  endfunction

  logic             wrInRange, wrOk;
  logic [IDX_W-1:0] wrIdx;

  always_comb begin
    wrInRange = int'(wr_index) < CELLS;
    wrIdx     = wrInRange ? wr_index : '0;
    wrOk      = wr_en && wrInRange && (wr_given || !given_q[wrIdx]);
  end

  // Clear sweep and cell writes share the store; host writes are only honoured while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      for (int i = 0; i < CELLS; i++) begin
        value_q[i] <= '0;
        given_q[i] <= 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (wrOk) begin
            value_q[wrIdx] <= wr_value;
            given_q[wrIdx] <= wr_given;
          end
          if (clr_start) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            ptr_q   <= '0;
          end
        end
        CLEAR: begin
          if (!given_q[ptr_q]) value_q[ptr_q] <= '0;
          if (int'(ptr_q) == CELLS - 1) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b1;
    end else if (blinkCnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blinkCnt_q   <= '0;
      blinkPhase_q <= ~blinkPhase_q;
    end else begin
      blinkCnt_q <= blinkCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q    <= '0;
      row_q    <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      inGrid_q <= 1'b0;
      pixReq_q <= 1'b0;
    end else begin
      col_q    <= h_cnt / CELL_L;
      row_q    <= v_cnt / CELL_L;
      ox_q     <= h_cnt % CELL_L;
      oy_q     <= v_cnt % CELL_L;
      inGrid_q <= (h_cnt < GPX_L) && (v_cnt < GPX_L);
      pixReq_q <= pix_req;
    end
  end

  logic [IDX_W-1:0] rdIdx;
  logic [3:0]       cellVal;
  logic             cellGiven, isLine, inGlyph, glyphLit, isCursor;
  logic [2:0]       gx, gy;
  logic [4:0]       glyphRow;
`ifdef SUDOKU_SAME_DIGIT_HL_EN
  logic [3:0]       curVal;
`endif

  always_comb begin
    rdIdx     = inGrid_q ? IDX_W'(row_q * GRID_L + col_q) : '0;
    cellVal   = value_q[rdIdx];
    cellGiven = given_q[rdIdx];
    isLine    = (ox_q == '0) || (oy_q == '0) ||
                (ox_q <= 10'd1 && (col_q % BOX_L) == '0) ||
                (oy_q <= 10'd1 && (row_q % BOX_L) == '0) ||
                (col_q == GRID_L - 10'd1 && ox_q == CELL_L - 10'd1) ||
                (row_q == GRID_L - 10'd1 && oy_q == CELL_L - 10'd1);
    inGlyph   = (ox_q >= X0_L) && (ox_q < X0_L + GW_L) && (oy_q >= Y0_L) && (oy_q < Y0_L + GH_L);
    gx        = 3'((ox_q - X0_L) / SCALE_L);
    gy        = 3'((oy_q - Y0_L) / SCALE_L);
    glyphRow  = fontRow(cellVal, gy);
    glyphLit  = inGlyph && (cellVal != '0) && (cellVal <= 4'd9) && glyphRow[3'd4 - gx];
    isCursor  = inGrid_q && (int'(cursor_index) < CELLS) && (rdIdx == cursor_index);
`ifdef SUDOKU_SAME_DIGIT_HL_EN
    curVal    = (int'(cursor_index) < CELLS) ? value_q[cursor_index] : '0;
`endif

    if (!inGrid_q)                     pixel_d = 12'h888;
    else if (isLine)                   pixel_d = 12'h000;
    else if (glyphLit)                 pixel_d = cellGiven ? 12'h000 : 12'h00F;
    else if (isCursor && blinkPhase_q) pixel_d = 12'hFF0;
`ifdef SUDOKU_SAME_DIGIT_HL_EN
    else if (!isCursor && cellVal != '0 && cellVal == curVal) pixel_d = 12'h8CF;
`endif
    else                               pixel_d = 12'hFFF;
  end

  // Pixel colour is held across idle (pix_req=0) slots; only the valid flag drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_q      <= 12'h000;
      pixelValid_q <= 1'b0;
    end else begin
      if (pixReq_q) pixel_q <= pixel_d;
      pixelValid_q <= pixReq_q;
    end
  end

  assign busy        = busy_q;
  assign pixel       = pixel_q;
  assign pixel_valid = pixelValid_q;

endmodule

// File: tb/tb_sudoku_grid_pixel_gen.sv
// Directed self-checking bench for sudoku_grid_pixel_gen (fast blink: BLINK_DIV=4).
module tb_sudoku_grid_pixel_gen;

  localparam int IDX_W = 7;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [9:0]       h_cnt, v_cnt;
  logic             pix_req, wr_en, wr_given, clr_start;
  logic [IDX_W-1:0] wr_index, cursor_index;
  logic [3:0]       wr_value;
  logic             busy, pixel_valid;
  logic [11:0]      pixel;

  int testsRun = 0;
  int testsFailed = 0;
  int cycCnt = 0;

  sudoku_grid_pixel_gen #(.BLINK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt), .pix_req(pix_req),
    .wr_en(wr_en), .wr_index(wr_index), .wr_value(wr_value), .wr_given(wr_given),
    .clr_start(clr_start), .cursor_index(cursor_index), .busy(busy),
    .pixel(pixel), .pixel_valid(pixel_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n) cycCnt <= cycCnt + 1;

  task automatic checkOutput(input string tag, input logic [11:0] got, input logic [11:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one coordinate at a negedge and return at the negedge after it has left S2.
  task automatic applyStimulus(input int h, input int v);
    h_cnt   = 10'(h);
    v_cnt   = 10'(v);
    pix_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic probe(input string tag, input int h, input int v, input logic [11:0] exp);
    applyStimulus(h, v);
    checkOutput(tag, pixel, exp);
  endtask

  task automatic writeCell(input int idx, input int val, input logic given);
    wr_en    = 1'b1;
    wr_index = IDX_W'(idx);
    wr_value = 4'(val);
    wr_given = given;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    int n;
    logic expPhase;
    rst_n = 1'b0; h_cnt = '0; v_cnt = '0; pix_req = 1'b0; wr_en = 1'b0;
    wr_given = 1'b0; clr_start = 1'b0; wr_index = '0; wr_value = '0;
    cursor_index = 7'd81;
    pix_req = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_pixel", pixel, 12'h000);
    checkOutput("rst_valid", {11'b0, pixel_valid}, 12'h000);
    checkOutput("rst_busy", {11'b0, busy}, 12'h000);
    rst_n = 1'b1;

    probe("origin_line", 0, 0, 12'h000);
    checkOutput("origin_valid", {11'b0, pixel_valid}, 12'h001);
    probe("empty_cell", 10, 10, 12'hFFF);
    probe("outside", 500, 10, 12'h888);
    h_cnt = 10'd10; v_cnt = 10'd10; pix_req = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    checkOutput("idle_valid", {11'b0, pixel_valid}, 12'h000);
    checkOutput("idle_hold", pixel, 12'h888);

    probe("right_edge", 467, 10, 12'h000);
    probe("right_out", 468, 10, 12'h888);
    probe("bottom_edge", 10, 467, 12'h000);
    probe("thin_line", 52, 10, 12'h000);
    probe("thin_ox1", 53, 10, 12'hFFF);
    probe("box_ox1", 157, 10, 12'h000);
    probe("box_oy1", 10, 157, 12'h000);

    writeCell(0, 8, 1'b1);
    probe("g8_gx2_gy0", 24, 12, 12'h000);
    probe("g8_gx0_gy0", 16, 12, 12'hFFF);
    probe("g8_gx4_gy0", 32, 12, 12'hFFF);
    probe("g8_gx1_gy3", 20, 24, 12'h000);
    probe("g8_right_out", 36, 12, 12'hFFF);
    writeCell(0, 3, 1'b0);
    probe("clue_protect", 16, 16, 12'h000);

    writeCell(10, 4, 1'b0);
    probe("user4", 76, 80, 12'h00F);
    writeCell(2, 15, 1'b0);
    probe("val15_a", 120, 16, 12'hFFF);
    probe("val15_b", 128, 12, 12'hFFF);

    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    wr_en = 1'b1; wr_index = 7'd20; wr_value = 4'd7; wr_given = 1'b1;
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
      wr_en = 1'b0;
    end
    wr_en = 1'b0;
    checkOutput("busy_cycles", 12'(n), 12'd81);
    probe("cleared_user", 76, 80, 12'hFFF);
    probe("clue_kept", 16, 16, 12'h000);
    probe("busy_write_ign", 128, 116, 12'hFFF);

    cursor_index = 7'd1;
    applyStimulus(60, 10);
    for (int i = 0; i < 16; i++) begin
      expPhase = ((((cycCnt - 1) / 4) % 2) == 0);
      checkOutput($sformatf("blink_%0d", i), pixel, expPhase ? 12'hFF0 : 12'hFFF);
      @(negedge clk);
    end
    cursor_index = 7'd81;
    applyStimulus(60, 10);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("nocursor_%0d", i), pixel, 12'hFFF);
      @(negedge clk);
    end

    writeCell(0, 5, 1'b1);
    writeCell(40, 5, 1'b0);
    cursor_index = 7'd0;
`ifdef SUDOKU_SAME_DIGIT_HL_EN
    probe("same_digit_hl", 216, 216, 12'h8CF);
`else
    probe("no_hl", 216, 216, 12'hFFF);
`endif
    probe("other_cell_bg", 268, 216, 12'hFFF);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/sudoku_grid_pixel_gen.md
Name: sudoku_grid_pixel_gen

Overview:
- Pipelined pixel generator for the Sudoku board on VGA.
- Holds a GRID_N x GRID_N cell value store and draws grid lines, box lines, the digit glyphs and a blinking cursor for each (h_cnt, v_cnt) coordinate from the VGA timing block.
- Replaces the per-cell combinational number renderer with a parametrised, clocked design that has a fixed latency.
- Output feeds the VGA RGB mux.

Parameters:
- GRID_N, 9: cells per row/column.
- BOX_N, 3: cells per box side; thick line every BOX_N cells.
- CELL_SIZE, 52: cell edge in pixels.
- GLYPH_SCALE, 4: 5x7 font scale factor.
- BLINK_DIV, 25000000: clk cycles per cursor blink half-period.
- IDX_W, 7: cell index width; must satisfy 2^IDX_W >= GRID_N*GRID_N.

Ports:
- clk  in  1  pixel-domain clock.
- rst_n  in  1  asynchronous active-low reset.
- h_cnt  in  10  horizontal pixel coordinate.
- v_cnt  in  10  vertical pixel coordinate.
- pix_req  in  1  coordinate valid (active video).
- wr_en  in  1  cell write strobe.
- wr_index  in  IDX_W  cell index = row*GRID_N+col.
- wr_value  in  4  digit 0..9; 0 = empty.
- wr_given  in  1  1 = puzzle clue, 0 = user entry.
- clr_start  in  1  pulse: begin clearing all user entries.
- cursor_index  in  IDX_W  selected cell.
- busy  out  1  clear sweep in progress.
- pixel  out  12  RGB444 colour.
- pixel_valid  out  1  pixel corresponds to pix_req issued 2 cycles earlier.

Behaviour:
- Reset: all cells value=0 and given=0; pixel=12'h000; pixel_valid=0; busy=0; blink counter=0; blink_phase=1.
- Pipeline, latency 2, throughput 1 per clk:
  - S1 registers cell col=h_cnt/CELL_SIZE, row=v_cnt/CELL_SIZE, offsets ox=h_cnt%CELL_SIZE, oy=v_cnt%CELL_SIZE, in_grid flag, and pix_req.
  - S2 reads the cell store, evaluates font and line tests, and registers pixel and pixel_valid.
- When pix_req=0, pixel_valid=0 two cycles later and pixel is held.
- in_grid: h_cnt < GRID_N*CELL_SIZE and v_cnt < GRID_N*CELL_SIZE.
- Colour priority, highest first:
  1. Outside grid -> 12'h888.
  2. Line -> 12'h000. A pixel is a line if:
     - ox==0 or oy==0, or
     - ox<=1 and col%BOX_N==0, or
     - oy<=1 and row%BOX_N==0, or
     - h_cnt==GRID_N*CELL_SIZE-1, or
     - v_cnt==GRID_N*CELL_SIZE-1.
  3. Glyph pixel lit -> 12'h000 if the cell is given, else 12'h00F.
  4. Cursor cell with blink_phase=1 -> 12'hFF0.
  5. Otherwise -> 12'hFFF.
- Glyph placement:
  - Origin x0=(CELL_SIZE-5*GLYPH_SCALE)/2, y0=(CELL_SIZE-7*GLYPH_SCALE)/2 (16, 12 at defaults).
  - gx=(ox-x0)/GLYPH_SCALE, gy=(oy-y0)/GLYPH_SCALE; lit only inside the 5x7 box and when value is 1..9.
  - Values 10..15 are never drawn.
  - Font row MSB = leftmost column. Digit 8 rows: 01110,10001,10001,01110,10001,10001,01110.
- Writes:
  - Registered. Visible to S2 reads starting the cycle after wr_en.
  - A same-cycle read of the written cell returns the old value.
  - wr_index >= GRID_N*GRID_N is ignored.
  - A write to a given cell with wr_given=0 is ignored (clues are protected).
- Clear FSM:
  - IDLE: clr_start -> CLEAR, busy=1, ptr=0.
  - CLEAR: one cell per cycle. If the cell is not given, value:=0. ptr increments.
  - At ptr==GRID_N*GRID_N-1 the FSM clears that cell and returns to IDLE; busy=0 the next cycle.
  - The sweep takes exactly GRID_N*GRID_N busy cycles.
  - wr_en and clr_start are ignored while busy. Rendering continues during the sweep.
- Blink:
  - Counter runs 0..BLINK_DIV-1; blink_phase toggles on wrap.
  - cursor_index >= GRID_N*GRID_N means no cursor is drawn.
- Reset asserted mid-sweep or mid-pipeline: immediate return to the reset state.

Optional Feature:
- Macro: SUDOKU_SAME_DIGIT_HL_EN.
- Defined:
  - Adds a second read port on cursor_index.
  - Non-cursor cells whose nonzero value equals the cursor cell's value use background 12'h8CF in place of 12'hFFF.
  - Priority is below the cursor and above plain background.
  - Latency is unchanged.
- Undefined: no second port; no highlight.

Test Plan:
- Reset then pix_req=1, h=0, v=0 -> after 2 clk pixel=12'h000, pixel_valid=1. Before release, pixel=0 and busy=0.
- Empty cell (h=10, v=10), cursor_index=80 -> 12'hFFF. Probe h=500, v=10 -> 12'h888.
- Write index 0 value 8 given=1, then probe h=24, v=12 (gx=2, gy=0) -> 12'h000. Probe h=16, v=12 (gx=0) -> 12'hFFF. A user write of 3 to index 0 is rejected.
- Write index 10 value 4 given=0, pulse clr_start -> busy high exactly 81 cycles. Afterwards index 10 renders no glyph and index 0 still shows 8. wr_en during busy has no effect.
- BLINK_DIV=4, cursor_index=1, probe h=60, v=10 -> pixel alternates 12'hFF0 / 12'hFFF every 4 clk.
- With SUDOKU_SAME_DIGIT_HL_EN: values 5 at indices 0 and 40, cursor_index=0 -> background pixel of cell 40 (h=216, v=216) is 12'h8CF.
